// File: rtl/serial_pair_serializer_if.sv
// Operand-pair handshake plus lockstep serial output bus for serial_pair_serializer.
// slave: the serializer itself. master: whoever offers pairs and consumes the serial bits.
interface serial_pair_serializer_if #(
    parameter int WIDTH = 8
);
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_a;
    logic [WIDTH-1:0] up_b;
    logic             out_valid;
    logic             out_a;
    logic             out_b;
    logic             out_first;
    logic             out_last;

    modport master (
        output up_valid, up_a, up_b,
        input  up_ready, out_valid, out_a, out_b, out_first, out_last
    );

    modport slave (
        input  up_valid, up_a, up_b,
        output up_ready, out_valid, out_a, out_b, out_first, out_last
    );
endinterface

// File: rtl/serial_pair_serializer.sv
// Purpose: shifts a WIDTH-bit operand pair out one bit per clock on two lockstep lines with first/last strobes.
// Latency: pair accepted at edge N shows its first bit after edge N, its last bit after edge N+WIDTH-1.
// Backpressure: none downstream; up_ready only in IDLE or on the last bit. SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN selects LSB-first.
module serial_pair_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_pair_serializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef logic [CW-1:0]    cnt_t;
    typedef logic [WIDTH-1:0] word_t;
    localparam cnt_t CNT_PRELAST = cnt_t'(WIDTH - 2);

`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
    localparam int OUT_BIT = 0;
    function automatic word_t advance(input word_t v);
        return {1'b0, v[WIDTH-1:1]};
    endfunction
`else
    localparam int OUT_BIT = WIDTH - 1;
    function automatic word_t advance(input word_t v);
        return {v[WIDTH-2:0], 1'b0};
    endfunction
`endif

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    word_t  sh_a_q, sh_a_d;
    word_t  sh_b_q, sh_b_d;
    logic   out_valid_q, out_valid_d;
    logic   out_first_q, out_first_d;
    logic   out_last_q, out_last_d;
    logic   up_ready;
    logic   xfer;
    logic   load;

    // Depends on registered state only, so upstream may wait on it before raising up_valid.
    assign up_ready = ~rst & ((state_q == ST_IDLE) | out_last_q);
    assign xfer     = bus.up_valid & up_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (out_last_q) begin
                    if (xfer) begin
                        load = 1'b1;
                    end else begin
                        // Shift registers are zeroed on the way out so out_a/out_b read 0 while idle.
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                        sh_a_d      = '0;
                        sh_b_d      = '0;
                        out_valid_d = 1'b0;
                        out_first_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end else begin
                    sh_a_d      = advance(sh_a_q);
                    sh_b_d      = advance(sh_b_q);
                    cnt_d       = cnt_q + cnt_t'(1);
                    out_first_d = 1'b0;
                    out_last_d  = (cnt_q == CNT_PRELAST);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d     = ST_SHIFT;
            cnt_d       = '0;
            sh_a_d      = bus.up_a;
            sh_b_d      = bus.up_b;
            out_valid_d = 1'b1;
            out_first_d = 1'b1;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.up_ready  = up_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = sh_a_q[OUT_BIT];
    assign bus.out_b     = sh_b_q[OUT_BIT];
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: doc/serial_pair_serializer.md
# serial_pair_serializer

Parallel-to-serial transmitter for the serial comparator family. Accepts a pair of WIDTH-bit operands over a valid/ready handshake and emits them one bit per clock on two lockstep serial lines, with word-framing strobes. Sits upstream of a serial comparator: `out_a`/`out_b` drive its `a`/`b` inputs, and `out_first` drives its per-word restart. Default bit order is most significant first.

## Interface

- `WIDTH`, default 8: operand width in bits; legal range is 2 or more.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `up_valid` input 1: operand pair offered.
- `up_ready` output 1: serializer can accept a pair this cycle.
- `up_a` input WIDTH: operand A.
- `up_b` input WIDTH: operand B.
- `out_valid` output 1: `out_a`/`out_b` carry a valid bit this cycle.
- `out_a` output 1: current serial bit of A.
- `out_b` output 1: current serial bit of B.
- `out_first` output 1: current bit is the first bit of a word.
- `out_last` output 1: current bit is the last bit of a word.

## Operation

- **State and storage.**
  - Two WIDTH-bit shift registers, `sh_a` and `sh_b`.
  - A bit counter of width $clog2(WIDTH).
  - A state bit with two states: IDLE and SHIFT.
- **Handshake.**
  - A transfer occurs on a rising edge with `up_valid & up_ready`.
  - `up_ready = ~rst & (IDLE | out_last)`. It is combinational from registered state only and never depends on `up_valid`.
- **IDLE state.**
  - All `out_*` are 0.
  - On a transfer: load `up_a`/`up_b` into the shift registers, clear the counter, go to SHIFT.
- **SHIFT state.**
  - `out_valid` = 1.
  - `out_a`/`out_b` are the current bits of the shift registers, MSB end by default.
  - `out_first` = 1 when counter = 0; `out_last` = 1 when counter = WIDTH-1.
  - Each cycle the registers shift by one toward the output end and the counter increments.
- **Leaving SHIFT on the last bit.**
  - If a transfer occurs on that edge, reload and stay in SHIFT with counter = 0. Back-to-back words have no bubble.
  - If no transfer occurs, go to IDLE.
- **Hold behaviour.** `up_a`/`up_b` are sampled only at the transfer edge. Changes at any other time have no effect.
- **No backpressure.** Once started, a word always completes in exactly WIDTH cycles.
- **Reset.**
  - Asynchronous assertion forces IDLE, counter 0, shift registers 0, and all `out_*` to 0.
  - `up_ready` = 0 while `rst` is high and 1 from the first cycle after deassertion.
  - A word in flight when reset asserts is discarded. No partial word resumes.

## Timing

- Outputs `out_*` are registered.
- **Latency.** Transfer at edge N: first bit is visible after edge N, last bit after edge N+WIDTH-1.
- **Throughput.** One word per WIDTH cycles when back-to-back.
- **Strobes.**
  - `out_first` and `out_last` are each high for exactly one cycle per word.
  - They are never high in the same cycle, because WIDTH is 2 or more.
- `out_valid` stays continuously high across back-to-back words.
- An idle gap of k cycles between words gives k cycles of `out_valid` = 0.

## Configuration

- Macro `SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN`.
- **Defined:** bits are emitted least significant first. Shift registers shift toward the LSB end, and `out_a`/`out_b` = bit 0.
- **Undefined (default):** bits are emitted most significant first. `out_a`/`out_b` = bit WIDTH-1.
- Handshake, framing and latency are identical in both builds.

## Test plan

All scenarios use WIDTH=8.

- **Single word, default build.** `up_a`=8'hA5, `up_b`=8'h3C, one transfer.
  - Over 8 cycles, `out_a` = 1,0,1,0,0,1,0,1 and `out_b` = 0,0,1,1,1,1,0,0.
  - `out_first` is high on cycle 1 only, `out_last` on cycle 8 only.
  - All outputs are 0 afterwards.
- **Back-to-back.** `up_valid` held high with pairs (8'h01, 8'h80) then (8'hFF, 8'h00).
  - `up_ready` is high only on the IDLE cycle and the two `out_last` cycles.
  - There are 16 contiguous `out_valid` cycles.
  - `out_a` = 0000_0001_1111_1111.
- **Gap.** Second pair offered 3 cycles after the first word's `out_last`.
  - Exactly 3 cycles of `out_valid` = 0 between words.
  - `out_first` reasserts with the second word's bit 0.
- **Reset mid-word.** Assert `rst` asynchronously after bit 3 of 8'hA5/8'h3C.
  - All `out_*` go to 0 immediately, without waiting for a clock edge.
  - After release, `up_ready` = 1.
  - A new pair 8'hF0/8'h0F serializes from its first bit.
- **LSB-first build.** Macro defined, pair (8'h01, 8'h80).
  - `out_a` = 1,0,0,0,0,0,0,0 and `out_b` = 0,0,0,0,0,0,0,1.
- **End-to-end with a serial comparator.**
  - Comparator `a`/`b` are driven from `out_a`/`out_b`, with its restart driven by `out_first`.
  - Pair 8'h64/8'h62: on `out_last` the comparator shows greater = 1.
  - Pair 8'h62/8'h62: the comparator shows equal = 1.
